piso_serializer: RTL and testbench

Parallel-in, serial-out stage that feeds the serial input `x` of the 4-bit serial-in shift register stage. It accepts a WIDTH-bit word over a valid/ready handshake and emits the word MSB-first, one bit per clock, with a bit-valid strobe and a start-of-frame marker. Back-to-back words stream with no idle gap. An optional even-parity bit can be appended to each word.

---
 rtl/piso_serializer.sv | 78 +++++++
 tb/tb_piso_serializer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, MSB-first bit stream out with sof and bit-valid strobes.
// Define PISO_PARITY_EN to append one even-parity bit after each word's LSB.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA
`ifdef PISO_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             at_end;
    logic             last;
    logic             accept;

    assign at_end = state == DATA && cnt == CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    logic par;
    assign last = state == PAR;
    assign x    = state == DATA ? sreg[WIDTH-1] : state == PAR ? par : 1'b0;
`else
    assign last = at_end;
    assign x    = state == DATA && sreg[WIDTH-1];
`endif

    assign din_ready = state == IDLE || last;
    assign accept    = din_valid && din_ready;
    assign x_valid   = state != IDLE;
    assign sof       = state == DATA && cnt == '0;
    assign busy      = x_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            state <= DATA;
            sreg  <= din;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= ^din;
`endif
        end else if (state == DATA) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= at_end ? '0 : cnt + 1'b1;
`ifdef PISO_PARITY_EN
            if (at_end) state <= PAR;
`else
            if (at_end) state <= IDLE;
`endif
        end
`ifdef PISO_PARITY_EN
        else if (state == PAR) state <= IDLE;
`endif
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized and directed words checked by a frame-level scoreboard.
module tb_piso_serializer;
    localparam int W = 4;

    typedef struct {
        logic b;
        logic s;
    } bit_t;

    logic         clk = 0;
    logic         rst = 0;
    logic [W-1:0] din = '0;
    logic         din_valid = 0;
    logic         din_ready, x, x_valid, sof, busy;
    logic [3:0]   sipo = '0;
    bit_t         q[$];
    int           checks = 0;
    int           errors = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid), .sof(sof), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (x_valid) sipo <= {sipo[2:0], x};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A frame is the word MSB-first, optionally followed by its even parity.
    task automatic push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) q.push_back('{b: w[i], s: i == W - 1});
`ifdef PISO_PARITY_EN
        q.push_back('{b: ^w, s: 1'b0});
`endif
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("din_ready", din_ready, q.size() <= 1);
            chk("busy_eq_valid", busy, x_valid);
            if (q.size() > 0) begin
                chk("x_valid", x_valid, 1);
                chk("x", x, q[0].b);
                chk("sof", sof, q[0].s);
                void'(q.pop_front());
            end else begin
                chk("idle_x_valid", x_valid, 0);
                chk("idle_x", x, 0);
                chk("idle_sof", sof, 0);
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        logic acc;
        @(negedge clk);
        din = w;
        din_valid = 1;
        for (int t = 0; t < 40; t++) begin
            #1 acc = din_ready;
            @(posedge clk);
            if (acc) begin
                push_frame(w);
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_x_valid"}, x_valid, 0);
        chk({tag, "_sof"}, sof, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_din_ready"}, din_ready, 1);
    endtask

    initial begin
        #50;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1;

        send(4'b1011);
        idle(W + 3);
`ifdef PISO_PARITY_EN
        chk("sipo_single", sipo, 4'b0111);
`else
        chk("sipo_single", sipo, 4'b1011);
`endif

        send(4'b1011);
        send(4'b0110);
        idle(W + 3);

        send(4'b0101);
        send(4'b1111);
        idle(W + 3);

        // Drop reset during the second bit; held valid must be ignored while in reset.
        send(4'b1011);
        @(posedge clk);
        #2 rst = 0;
        q.delete();
        din = 4'b1111;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        din_valid = 0;
        rst = 1;
        idle(2);
        send(4'b0001);
        idle(W + 3);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send(W'($urandom));
        end
        idle(1);
        for (int t = 0; t < 40 && q.size() > 0; t++) @(negedge clk);
        chk("drain", q.size(), 0);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
